// File: rtl/sn74ls55_arbiter_if.sv
// Bus bundle between the two requesters and the AND-NOR arbiter.
// master: requester side (drives requests and AND terms, sees grants and y).
// slave : arbiter side.
interface sn74ls55_arbiter_if;
  logic       req0;
  logic       req1;
  logic [3:0] t0;
  logic [3:0] t1;
  logic       gnt0;
  logic       gnt1;
  logic       busy;
  logic       y;

  modport master (
    output req0, req1, t0, t1,
    input  gnt0, gnt1, busy, y
  );

  modport slave (
    input  req0, req1, t0, t1,
    output gnt0, gnt1, busy, y
  );
endinterface

// File: rtl/sn74ls55_arbiter.sv
// Two-requester round-robin arbiter in front of a 2-wide, 4-input AND-NOR gate.
// Only the granted requester's AND term reaches the NOR; the result is registered on y.
// A contested grant is held for at most HOLD consecutive cycles before rotating.
// Optional build macro SN74LS55_ARBITER_LOCK_EN adds a lock input that suppresses
// forced rotation while asserted (counter saturates at HOLD-1).
//
// state | meaning
// ------+----------------------------------------------
// IDLE  | no grant, y forced high
// G0    | requester 0 owns the gate (term t0 reaches NOR)
// G1    | requester 1 owns the gate (term t1 reaches NOR)
module sn74ls55_arbiter #(
  parameter int HOLD = 4,
  parameter int CW   = 3
) (
  input  logic clk,
  input  logic clr_n,
`ifdef SN74LS55_ARBITER_LOCK_EN
  input  logic lock,
`endif
  sn74ls55_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, G0 = 2'd1, G1 = 2'd2} state_e;

  localparam logic [CW-1:0] HOLD_M1 = CW'(HOLD - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_q, last_d;
  logic          gnt0_q, gnt0_d;
  logic          gnt1_q, gnt1_d;
  logic          busy_q, busy_d;
  logic          y_q, y_d;

  logic          lock_v;
  logic          own_req;
  logic          oth_req;
  state_e        other_s;

`ifdef SN74LS55_ARBITER_LOCK_EN
  assign lock_v = lock;
`else
  assign lock_v = 1'b0;
`endif

  // Next-state, hold counter, tie-break memory and registered-output values.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    own_req = 1'b0;
    oth_req = 1'b0;
    other_s = IDLE;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.req0 && !bus.req1)      state_d = G0;
        else if (bus.req1 && !bus.req0) state_d = G1;
        else if (bus.req0 && bus.req1)  state_d = last_q ? G0 : G1;
        else                            state_d = IDLE;
      end
      G0, G1: begin
        own_req = (state_q == G0) ? bus.req0 : bus.req1;
        oth_req = (state_q == G0) ? bus.req1 : bus.req0;
        other_s = (state_q == G0) ? G1 : G0;
        if (!own_req) begin
          // Release: hand straight over if the other side waits, else go idle.
          cnt_d   = '0;
          state_d = oth_req ? other_s : IDLE;
        end else if (!oth_req) begin
          cnt_d = '0;
        end else if (cnt_q < HOLD_M1) begin
          cnt_d = cnt_q + CW'(1);
        end else if (lock_v) begin
          cnt_d = HOLD_M1;
        end else begin
          cnt_d   = '0;
          state_d = other_s;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    if (state_d == G0) last_d = 1'b0;
    if (state_d == G1) last_d = 1'b1;

    gnt0_d = (state_d == G0);
    gnt1_d = (state_d == G1);
    busy_d = (state_d != IDLE);
    // y uses the grant held during this cycle, not the one being computed.
    y_d    = ~((&bus.t0 & gnt0_q) | (&bus.t1 & gnt1_q));
  end

  // All state and outputs registered; synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      busy_q  <= 1'b0;
      y_q     <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      busy_q  <= busy_d;
      y_q     <= y_d;
    end
  end

  assign bus.gnt0 = gnt0_q;
  assign bus.gnt1 = gnt1_q;
  assign bus.busy = busy_q;
  assign bus.y    = y_q;

endmodule
